pu_riscv_muldiv_wb: RTL and testbench

// - Writeback collector directly downstream of the multiply and divide units in the execute stage.
// - Tags each M-extension instruction with its destination register at issue.
// - Captures mul/div results when their bubble flag is low and queues them in a 2-entry result FIFO.
// - Drives registered register-file writes and a RAW-hazard flag back to decode.
//

---
 rtl/pu_riscv_muldiv_wb.sv | 204 ++++++++++++++++++++
 tb/tb_pu_riscv_muldiv_wb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_muldiv_wb.sv
// Writeback collector for the M-extension multiply/divide units.
// Tags issued mul/div ops with their rd, queues results in a 2-entry FIFO,
// drives registered register-file writes and a RAW-hazard flag to decode.
// Optional feature: define PU_RISCV_MULDIV_BYPASS_EN to let a result skip the
// empty FIFO and load the writeback registers directly.
module pu_riscv_muldiv_wb #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall_i,
    input  logic            id_bubble_i,
    input  logic [ILEN-1:0] id_instr_i,
    input  logic            mul_bubble_i,
    input  logic [XLEN-1:0] mul_r_i,
    input  logic            div_bubble_i,
    input  logic [XLEN-1:0] div_r_i,
    input  logic            wb_stall_i,
    output logic            wb_we_o,
    output logic [4:0]      wb_dst_o,
    output logic [XLEN-1:0] wb_r_o,
    output logic            md_full_o,
    output logic            md_hazard_o,
    output logic            md_ovf_o
);

`ifdef PU_RISCV_MULDIV_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    // Issue decode
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       is_mext, issue_mul, issue_div;

    assign id_rd     = id_instr_i[11:7];
    assign id_rs1    = id_instr_i[19:15];
    assign id_rs2    = id_instr_i[24:20];
    assign is_mext   = ((id_instr_i[6:2] == 5'b01100) || (id_instr_i[6:2] == 5'b01110)) &&
                       (id_instr_i[31:25] == 7'b0000001);
    assign issue_mul = !ex_stall_i && !id_bubble_i && is_mext && !id_instr_i[14];
    assign issue_div = !ex_stall_i && !id_bubble_i && is_mext && id_instr_i[14];

    logic unused_instr;
    if (ILEN > 32) begin : g_wide_instr
        assign unused_instr = ^{id_instr_i[ILEN-1:32], id_instr_i[13:12], id_instr_i[1:0]};
    end else begin : g_narrow_instr
        assign unused_instr = ^{id_instr_i[13:12], id_instr_i[1:0]};
    end

    // State
    logic            mul_v_q, mul_v_d, div_v_q, div_v_d;
    logic [4:0]      mul_rd_q, mul_rd_d, div_rd_q, div_rd_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [4:0]      fifo_rd_q [2];
    logic [4:0]      fifo_rd_d [2];
    logic [XLEN-1:0] fifo_data_q [2];
    logic [XLEN-1:0] fifo_data_d [2];
    logic            ovf_q, ovf_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_dst_q, wb_dst_d;
    logic [XLEN-1:0] wb_r_q, wb_r_d;

    // Arriving results; an untagged result is carried with rd=0 so it is never written
    logic       mul_valid, div_valid;
    logic [4:0] mul_res_rd, div_res_rd;

    assign mul_valid  = !mul_bubble_i;
    assign div_valid  = !div_bubble_i;
    assign mul_res_rd = mul_v_q ? mul_rd_q : 5'd0;
    assign div_res_rd = div_v_q ? div_rd_q : 5'd0;

    // Tag next-state: capture clears the tag, a same-cycle issue re-arms it
    always_comb begin
        mul_v_d  = mul_v_q;
        mul_rd_d = mul_rd_q;
        div_v_d  = div_v_q;
        div_rd_d = div_rd_q;
        if (mul_valid) mul_v_d = 1'b0;
        if (div_valid) div_v_d = 1'b0;
        if (issue_mul) begin
            mul_v_d  = 1'b1;
            mul_rd_d = id_rd;
        end
        if (issue_div) begin
            div_v_d  = 1'b1;
            div_rd_d = id_rd;
        end
    end

    // FIFO and writeback next-state: pop first, then append mul then div
    logic pop, byp_mul, byp_div, push_mul, push_div;

    always_comb begin
        pop      = !wb_stall_i && (cnt_q != 2'd0);
        byp_mul  = BypassEn && (cnt_q == 2'd0) && !wb_stall_i && mul_valid;
        byp_div  = BypassEn && (cnt_q == 2'd0) && !wb_stall_i && div_valid && !mul_valid;
        push_mul = mul_valid && !byp_mul;
        push_div = div_valid && !byp_div;

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        wb_we_d     = wb_we_q;
        wb_dst_d    = wb_dst_q;
        wb_r_d      = wb_r_q;

        if (pop) begin
            fifo_rd_d[0]   = fifo_rd_q[1];
            fifo_data_d[0] = fifo_data_q[1];
            cnt_d          = cnt_q - 2'd1;
        end
        if (push_mul) begin
            if (cnt_d == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                fifo_rd_d[cnt_d[0]]   = mul_res_rd;
                fifo_data_d[cnt_d[0]] = mul_r_i;
                cnt_d                 = cnt_d + 2'd1;
            end
        end
        if (push_div) begin
            if (cnt_d == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                fifo_rd_d[cnt_d[0]]   = div_res_rd;
                fifo_data_d[cnt_d[0]] = div_r_i;
                cnt_d                 = cnt_d + 2'd1;
            end
        end

        if (!wb_stall_i) begin
            if (pop) begin
                wb_we_d  = (fifo_rd_q[0] != 5'd0);
                wb_dst_d = fifo_rd_q[0];
                wb_r_d   = fifo_data_q[0];
            end else if (byp_mul) begin
                wb_we_d  = (mul_res_rd != 5'd0);
                wb_dst_d = mul_res_rd;
                wb_r_d   = mul_r_i;
            end else if (byp_div) begin
                wb_we_d  = (div_res_rd != 5'd0);
                wb_dst_d = div_res_rd;
                wb_r_d   = div_r_i;
            end else begin
                wb_we_d  = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_v_q        <= 1'b0;
            mul_rd_q       <= 5'd0;
            div_v_q        <= 1'b0;
            div_rd_q       <= 5'd0;
            cnt_q          <= 2'd0;
            fifo_rd_q[0]   <= 5'd0;
            fifo_rd_q[1]   <= 5'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            ovf_q          <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_dst_q       <= 5'd0;
            wb_r_q         <= '0;
        end else begin
            mul_v_q     <= mul_v_d;
            mul_rd_q    <= mul_rd_d;
            div_v_q     <= div_v_d;
            div_rd_q    <= div_rd_d;
            cnt_q       <= cnt_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            ovf_q       <= ovf_d;
            wb_we_q     <= wb_we_d;
            wb_dst_q    <= wb_dst_d;
            wb_r_q      <= wb_r_d;
        end
    end

    // RAW hazard against pending tags and occupied FIFO entries
    function automatic logic rs_pending(input logic [4:0] rs);
        logic hit;
        hit = (mul_v_q && (rs == mul_rd_q)) || (div_v_q && (rs == div_rd_q)) ||
              ((cnt_q != 2'd0) && (rs == fifo_rd_q[0])) ||
              ((cnt_q == 2'd2) && (rs == fifo_rd_q[1]));
        return (rs != 5'd0) && hit;
    endfunction

    always_comb begin
        md_hazard_o = !id_bubble_i && (rs_pending(id_rs1) || rs_pending(id_rs2));
    end

    assign md_full_o = (cnt_q == 2'd2);
    assign md_ovf_o  = ovf_q;
    assign wb_we_o   = wb_we_q;
    assign wb_dst_o  = wb_dst_q;
    assign wb_r_o    = wb_r_q;

endmodule

// File: tb/tb_pu_riscv_muldiv_wb.sv
// Self-checking bench for pu_riscv_muldiv_wb: a table of single-op vectors
// plus directed sequences for dual capture, stall/overflow, hazard and reset.
module tb_pu_riscv_muldiv_wb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            ex_stall, id_bubble, mul_bubble, div_bubble, wb_stall;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] mul_r, div_r;
    logic            wb_we, md_full, md_hazard, md_ovf;
    logic [4:0]      wb_dst;
    logic [XLEN-1:0] wb_r;

    int n_cmp  = 0;
    int n_fail = 0;

    pu_riscv_muldiv_wb #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ex_stall_i  (ex_stall),
        .id_bubble_i (id_bubble),
        .id_instr_i  (id_instr),
        .mul_bubble_i(mul_bubble),
        .mul_r_i     (mul_r),
        .div_bubble_i(div_bubble),
        .div_r_i     (div_r),
        .wb_stall_i  (wb_stall),
        .wb_we_o     (wb_we),
        .wb_dst_o    (wb_dst),
        .wb_r_o      (wb_r),
        .md_full_o   (md_full),
        .md_hazard_o (md_hazard),
        .md_ovf_o    (md_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  f7;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        use_div;
        logic [63:0] data;
        logic        exp_we;
        logic [4:0]  exp_dst;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {32'd0, f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] instr);
        id_instr  = instr;
        id_bubble = 1'b0;
        tick();
        id_bubble = 1'b1;
    endtask

    initial begin
        // op codes: 0110011 OP, 0111011 OP-32, 0010011 OP-IMM
        vecs[0] = '{7'h01, 7'b0110011, 3'b100, 5'd5,  1'b1, 64'h7,                 1'b1, 5'd5};
        vecs[1] = '{7'h01, 7'b0110011, 3'b000, 5'd3,  1'b0, 64'hDEADBEEF,          1'b1, 5'd3};
        vecs[2] = '{7'h01, 7'b0111011, 3'b000, 5'd31, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31};
        vecs[3] = '{7'h01, 7'b0111011, 3'b101, 5'd12, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 5'd12};
        vecs[4] = '{7'h01, 7'b0110011, 3'b110, 5'd1,  1'b1, 64'h0,                 1'b1, 5'd1};
        vecs[5] = '{7'h01, 7'b0110011, 3'b000, 5'd0,  1'b0, 64'h55,                1'b0, 5'd0};
        vecs[6] = '{7'h01, 7'b0110011, 3'b011, 5'd17, 1'b0, 64'h8000_0000_0000_0001, 1'b1, 5'd17};
        vecs[7] = '{7'h00, 7'b0110011, 3'b000, 5'd7,  1'b0, 64'hAA,                1'b0, 5'd0};
        vecs[8] = '{7'h01, 7'b0010011, 3'b100, 5'd8,  1'b1, 64'hBB,                1'b0, 5'd0};

        rstn = 1'b0; ex_stall = 1'b0; id_bubble = 1'b1; id_instr = '0;
        mul_bubble = 1'b1; div_bubble = 1'b1; mul_r = '0; div_r = '0; wb_stall = 1'b0;
        tick();
        tick();
        check("reset wb_we", 64'(wb_we), 64'd0);
        check("reset wb_dst", 64'(wb_dst), 64'd0);
        check("reset wb_r", wb_r, 64'd0);
        check("reset md_full", 64'(md_full), 64'd0);
        check("reset md_ovf", 64'(md_ovf), 64'd0);
        rstn = 1'b1;
        tick();

        // Single-op vectors
        for (int i = 0; i < 9; i++) begin
            issue(enc(vecs[i].f7, 5'd0, 5'd0, vecs[i].f3, vecs[i].rd, vecs[i].op));
            if (vecs[i].use_div) begin
                div_bubble = 1'b0; div_r = vecs[i].data;
            end else begin
                mul_bubble = 1'b0; mul_r = vecs[i].data;
            end
            tick();
            mul_bubble = 1'b1; div_bubble = 1'b1;
`ifndef PU_RISCV_MULDIV_BYPASS_EN
            check($sformatf("vec%0d latency wb_we", i), 64'(wb_we), 64'd0);
            tick();
`endif
            check($sformatf("vec%0d wb_we", i), 64'(wb_we), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d wb_dst", i), 64'(wb_dst), 64'(vecs[i].exp_dst));
            check($sformatf("vec%0d wb_r", i), wb_r, vecs[i].data);
            tick();
            check($sformatf("vec%0d drained wb_we", i), 64'(wb_we), 64'd0);
            check($sformatf("vec%0d drained md_full", i), 64'(md_full), 64'd0);
        end

        // MUL x3 and DIV x4 results in the same cycle: mul written first
        issue(enc(7'h01, 5'd0, 5'd0, 3'b000, 5'd3, 7'b0110011));
        issue(enc(7'h01, 5'd0, 5'd0, 3'b100, 5'd4, 7'b0110011));
        mul_bubble = 1'b0; mul_r = 64'h33; div_bubble = 1'b0; div_r = 64'h44;
        tick();
        mul_bubble = 1'b1; div_bubble = 1'b1;
`ifndef PU_RISCV_MULDIV_BYPASS_EN
        check("dual md_full", 64'(md_full), 64'd1);
        tick();
`endif
        check("dual first wb_dst", 64'(wb_dst), 64'd3);
        check("dual first wb_r", wb_r, 64'h33);
        check("dual first wb_we", 64'(wb_we), 64'd1);
        tick();
        check("dual second wb_dst", 64'(wb_dst), 64'd4);
        check("dual second wb_r", wb_r, 64'h44);
        check("dual second wb_we", 64'(wb_we), 64'd1);
        tick();
        check("dual idle wb_we", 64'(wb_we), 64'd0);

        // Stall with three results: third dropped, overflow sticky
        wb_stall = 1'b1;
        issue(enc(7'h01, 5'd0, 5'd0, 3'b000, 5'd10, 7'b0110011));
        mul_bubble = 1'b0; mul_r = 64'hA1;
        id_instr = enc(7'h01, 5'd0, 5'd0, 3'b100, 5'd11, 7'b0110011); id_bubble = 1'b0;
        tick();
        mul_bubble = 1'b1;
        check("stall one md_full", 64'(md_full), 64'd0);
        div_bubble = 1'b0; div_r = 64'hB2;
        id_instr = enc(7'h01, 5'd0, 5'd0, 3'b000, 5'd12, 7'b0110011);
        tick();
        div_bubble = 1'b1; id_bubble = 1'b1;
        check("stall two md_full", 64'(md_full), 64'd1);
        check("stall two md_ovf", 64'(md_ovf), 64'd0);
        check("stall wb_we held", 64'(wb_we), 64'd0);
        id_instr = enc(7'h00, 5'd0, 5'd11, 3'b000, 5'd1, 7'b0110011); id_bubble = 1'b0;
        #1;
        check("hazard on fifo entry", 64'(md_hazard), 64'd1);
        id_bubble = 1'b1;
        mul_bubble = 1'b0; mul_r = 64'hC3;
        tick();
        mul_bubble = 1'b1;
        check("stall three md_ovf", 64'(md_ovf), 64'd1);
        check("stall three md_full", 64'(md_full), 64'd1);
        wb_stall = 1'b0;
        tick();
        check("unstall first wb_dst", 64'(wb_dst), 64'd10);
        check("unstall first wb_r", wb_r, 64'hA1);
        check("unstall first wb_we", 64'(wb_we), 64'd1);
        tick();
        check("unstall second wb_dst", 64'(wb_dst), 64'd11);
        check("unstall second wb_r", wb_r, 64'hB2);
        tick();
        check("unstall done wb_we", 64'(wb_we), 64'd0);
        check("unstall done md_full", 64'(md_full), 64'd0);
        check("ovf sticky", 64'(md_ovf), 64'd1);

        // Hazard against a pending divide tag
        issue(enc(7'h01, 5'd0, 5'd0, 3'b100, 5'd9, 7'b0110011));
        id_instr = enc(7'h00, 5'd2, 5'd9, 3'b000, 5'd1, 7'b0110011); id_bubble = 1'b0;
        #1;
        check("hazard rs1 x9", 64'(md_hazard), 64'd1);
        id_instr = enc(7'h00, 5'd9, 5'd2, 3'b000, 5'd1, 7'b0110011);
        #1;
        check("hazard rs2 x9", 64'(md_hazard), 64'd1);
        id_instr = enc(7'h00, 5'd2, 5'd6, 3'b000, 5'd1, 7'b0110011);
        #1;
        check("no hazard other regs", 64'(md_hazard), 64'd0);
        id_bubble = 1'b1;
        id_instr = enc(7'h00, 5'd2, 5'd9, 3'b000, 5'd1, 7'b0110011);
        #1;
        check("no hazard when bubble", 64'(md_hazard), 64'd0);
        id_bubble = 1'b0;
        id_instr = enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011);
        #1;
        check("no hazard x0 vs rd0", 64'(md_hazard), 64'd0);
        id_bubble = 1'b1;
        div_bubble = 1'b0; div_r = 64'h99;
        tick();
        div_bubble = 1'b1;
        tick();
        tick();

        // Reset while a DIV is pending and the FIFO holds one entry
        issue(enc(7'h01, 5'd0, 5'd0, 3'b100, 5'd20, 7'b0110011));
        issue(enc(7'h01, 5'd0, 5'd0, 3'b000, 5'd21, 7'b0110011));
        wb_stall = 1'b1;
        tick();
        mul_bubble = 1'b0; mul_r = 64'h77;
        tick();
        mul_bubble = 1'b1;
        tick();
        check("prereset wb_dst", 64'(wb_dst), 64'd9);
        rstn = 1'b0;
        id_instr = enc(7'h00, 5'd21, 5'd20, 3'b000, 5'd1, 7'b0110011); id_bubble = 1'b0;
        #1;
        check("midreset wb_we", 64'(wb_we), 64'd0);
        check("midreset wb_dst", 64'(wb_dst), 64'd0);
        check("midreset wb_r", wb_r, 64'd0);
        check("midreset md_full", 64'(md_full), 64'd0);
        check("midreset md_ovf", 64'(md_ovf), 64'd0);
        check("midreset md_hazard", 64'(md_hazard), 64'd0);
        id_bubble = 1'b1;
        wb_stall = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        div_bubble = 1'b0; div_r = 64'h66;
        tick();
        div_bubble = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("postreset cycle%0d wb_we", k), 64'(wb_we), 64'd0);
            tick();
        end
        check("postreset wb_dst", 64'(wb_dst), 64'd0);
        check("postreset md_full", 64'(md_full), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
